// File: rtl/vliw_rf_pkg.sv
// ============================================================================
// Module      : vliw_rf_pkg
// Description : Shared widths, requester indices and helpers for the VLIW
//               register-file writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vliw_rf_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_AW    = 5;
    localparam int PROT_REGS = 3;
    localparam int CNT_W     = 16;
    localparam int NREQ      = 3;

    localparam int REQ_LD = 0;
    localparam int REQ_L0 = 1;
    localparam int REQ_L1 = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Next requester index in round-robin order (wraps 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Requester handshake and register-file write-port bundle.
//               slave = arbiter side, master = requesters / register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if;
    import vliw_rf_pkg::*;

    logic      [NREQ-1:0] req_valid;
    reg_addr_t [NREQ-1:0] req_rd;
    data_t     [NREQ-1:0] req_data;
    logic      [NREQ-1:0] req_ready;
    logic                 regWrite1;
    logic                 regWrite2;
    reg_addr_t            rd1;
    reg_addr_t            rd2;
    data_t                writeData1;
    data_t                writeData2;
    logic [CNT_W-1:0]     drop_cnt;

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, regWrite1, regWrite2, rd1, rd2,
               writeData1, writeData2, drop_cnt
    );

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, regWrite1, regWrite2, rd1, rd2,
               writeData1, writeData2, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/wb_hold_entry.sv
// ============================================================================
// Module      : wb_hold_entry
// Description : One-deep result buffer (pend/rd/data). Load has priority
//               over clear so a retiring entry can be refilled in place.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_hold_entry
    import vliw_rf_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      load_i,
    input  wire logic      clear_i,
    input  wire reg_addr_t rd_i,
    input  wire data_t     data_i,
    output logic           pend_o,
    output reg_addr_t      rd_o,
    output data_t          data_o
);

    logic      pend_q;
    reg_addr_t rd_q;
    data_t     data_q;

    // Capture a new result on handshake, otherwise drop it once retired.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (load_i) begin
            pend_q <= 1'b1;
            rd_q   <= rd_i;
            data_q <= data_i;
        end else if (clear_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pend_o = pend_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Schedules up to three buffered results onto two register-file
//               write ports with WAW ordering, round-robin fairness and
//               discard of protected destinations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import vliw_rf_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    wb_port_arbiter_if.slave   bus
);

    localparam int SUM_W = CNT_W + 1;

    logic      [NREQ-1:0] pend;
    reg_addr_t [NREQ-1:0] e_rd;
    data_t     [NREQ-1:0] e_data;
    logic      [NREQ-1:0] load;
    logic      [NREQ-1:0] grant;
    logic      [NREQ-1:0] prot;
    logic      [NREQ-1:0] live;
    logic      [NREQ-1:0] elig;
    logic      [NREQ-1:0] assigned;

    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [SUM_W-1:0] drop_sum;
    logic [2:0]       idx;
    logic [1:0]       sel1, sel2;
    logic             hit1, hit2;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_entry
            wb_hold_entry u_entry (
                .clk     (clk),
                .reset   (reset),
                .load_i  (load[gi]),
                .clear_i (grant[gi]),
                .rd_i    (bus.req_rd[gi]),
                .data_i  (bus.req_data[gi]),
                .pend_o  (pend[gi]),
                .rd_o    (e_rd[gi]),
                .data_o  (e_data[gi])
            );
        end
    endgenerate

    // Classify entries: protected ones retire silently; a younger entry is
    // masked while an older live entry targets the same register.
    always_comb begin
        prot = '0;
        live = '0;
        for (int i = 0; i < NREQ; i++) begin
            prot[i] = pend[i] && (e_rd[i] < REG_AW'(PROT_REGS));
            live[i] = pend[i] && !prot[i];
        end
        elig = live;
        for (int j = 1; j < NREQ; j++) begin
            for (int i = 0; i < j; i++) begin
                if (live[i] && live[j] && (e_rd[i] == e_rd[j])) begin
                    elig[j] = 1'b0;
                end
            end
        end
    end

    // Round-robin scan from rr_q: first eligible hit to port 1, second to port 2.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        sel1     = 2'd0;
        sel2     = 2'd0;
        idx      = 3'd0;
        assigned = '0;
        rr_d     = rr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (elig[idx[1:0]]) begin
                if (!hit1) begin
                    hit1 = 1'b1;
                    sel1 = idx[1:0];
                end else if (!hit2) begin
                    hit2 = 1'b1;
                    sel2 = idx[1:0];
                end
            end
        end
        if (hit1) begin
            assigned[sel1] = 1'b1;
            rr_d           = rr_next(sel1);
        end
        if (hit2) begin
            assigned[sel2] = 1'b1;
            rr_d           = rr_next(sel2);
        end
    end

    // Retirement, handshake and saturating drop accumulation.
    always_comb begin
        grant    = prot | assigned;
        drop_sum = {1'b0, drop_q} + SUM_W'(prot[0]) + SUM_W'(prot[1]) + SUM_W'(prot[2]);
        drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    assign bus.req_ready = reset ? '0 : (~pend | grant);
    assign load          = bus.req_valid & bus.req_ready;

    // Round-robin pointer and drop counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q   <= 2'd0;
            drop_q <= '0;
        end else begin
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    // Write ports read straight from the hold entries; idle ports drive zero.
    assign bus.regWrite1  = hit1 && !reset;
    assign bus.regWrite2  = hit2 && !reset;
    assign bus.rd1        = bus.regWrite1 ? e_rd[sel1]   : '0;
    assign bus.rd2        = bus.regWrite2 ? e_rd[sel2]   : '0;
    assign bus.writeData1 = bus.regWrite1 ? e_data[sel1] : '0;
    assign bus.writeData2 = bus.regWrite2 ? e_data[sel2] : '0;
    assign bus.drop_cnt   = drop_q;

endmodule

`default_nettype wire
